// File: rtl/oam_dma_arbiter_if.sv
// rtl/oam_dma_arbiter_if.sv - CPU, PPU, system-bus and OAM RAM signals around the OAM DMA arbiter.
interface oam_dma_if;
  logic [15:0] ADDR;
  logic        WR;
  logic        RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  OAM_CPU_DATA;
  logic [1:0]  PPU_MODE;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_OAM_DATA;
  logic [15:0] SRC_ADDR;
  logic        SRC_RD;
  logic [7:0]  SRC_DATA;
  logic [7:0]  OAM_ADDR;
  logic        OAM_WE;
  logic [7:0]  OAM_WDATA;
  logic [7:0]  OAM_RDATA;
  logic        DMA_ACTIVE;

  modport master (
    input  ADDR, WR, RD, MMIO_DATA_out, PPU_MODE, PPU_RD, PPU_ADDR, SRC_DATA, OAM_RDATA,
    output OAM_CPU_DATA, PPU_OAM_DATA, SRC_ADDR, SRC_RD, OAM_ADDR, OAM_WE, OAM_WDATA, DMA_ACTIVE
  );

  modport slave (
    output ADDR, WR, RD, MMIO_DATA_out, PPU_MODE, PPU_RD, PPU_ADDR, SRC_DATA, OAM_RDATA,
    input  OAM_CPU_DATA, PPU_OAM_DATA, SRC_ADDR, SRC_RD, OAM_ADDR, OAM_WE, OAM_WDATA, DMA_ACTIVE
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - OAM DMA sequencer (FF46 trigger) and OAM port arbiter (DMA > PPU > CPU).
module oam_dma_arbiter #(
  parameter int STEP_CYCLES = 4,
  parameter int OAM_BYTES   = 160
) (
  input  logic         clk,
  input  logic         rst,
  oam_dma_if.master    bus
);

  localparam int              STEP_W    = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [7:0]      LAST_IDX  = 8'(OAM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_WRITE,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        base_q, base_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic trigger;
  logic byte_done;
  logic dma_active;
  logic dma_owns;
  logic ppu_busy;
  logic ppu_oam_sel;
  logic cpu_oam_sel;
  logic cpu_unusable_sel;
  logic cpu_blocked;

  assign trigger   = bus.WR && (bus.ADDR == 16'hFF46);
  // step_q counts cycles within one byte: READ=0, WRITE=1, WAIT=2..STEP_CYCLES-1
  assign byte_done = ((state_q == S_WRITE) || (state_q == S_WAIT)) && (step_q == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 8'h00;
      base_q  <= 8'h00;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    step_d  = step_q;

    case (state_q)
      S_SETUP: begin
        state_d = S_READ;
        step_d  = '0;
      end
      S_READ: begin
        state_d = S_WRITE;
        step_d  = step_q + 1'b1;
      end
      S_WRITE, S_WAIT: begin
        if (byte_done) begin
          step_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = 8'h00;
          end else begin
            state_d = S_READ;
            idx_d   = idx_q + 8'd1;
          end
        end else begin
          state_d = S_WAIT;
          step_d  = step_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A trigger always restarts; echo RAM sources E0-FF fold down to C0-DF
    if (trigger) begin
      base_d  = (bus.MMIO_DATA_out >= 8'hE0) ? (bus.MMIO_DATA_out & 8'hDF) : bus.MMIO_DATA_out;
      idx_d   = 8'h00;
      step_d  = '0;
      state_d = S_SETUP;
    end
  end

  assign dma_active       = (state_q != S_IDLE);
  assign dma_owns         = (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_WAIT);
  assign ppu_busy         = bus.PPU_MODE[1];
  assign ppu_oam_sel      = (bus.PPU_ADDR[15:8] == 8'hFE);
  assign cpu_oam_sel      = (bus.ADDR[15:8] == 8'hFE) && (bus.ADDR[7:0] < 8'hA0);
  assign cpu_unusable_sel = (bus.ADDR[15:8] == 8'hFE) && (bus.ADDR[7:0] >= 8'hA0);
  assign cpu_blocked      = dma_active || ppu_busy;

  always_comb begin
    bus.SRC_RD    = 1'b0;
    bus.SRC_ADDR  = 16'h0000;
    bus.OAM_ADDR  = 8'h00;
    bus.OAM_WE    = 1'b0;
    bus.OAM_WDATA = 8'h00;

    if (!rst) begin
      if (dma_owns) begin
        bus.OAM_ADDR = idx_q;
        if (state_q == S_READ) begin
          bus.SRC_RD   = 1'b1;
          bus.SRC_ADDR = {base_q, idx_q};
        end
        if (state_q == S_WRITE) begin
          bus.OAM_WE    = 1'b1;
          bus.OAM_WDATA = bus.SRC_DATA;
        end
      end else if (ppu_busy && bus.PPU_RD && ppu_oam_sel) begin
        bus.OAM_ADDR = bus.PPU_ADDR[7:0];
      end else if (cpu_oam_sel && (bus.RD || bus.WR)) begin
        bus.OAM_ADDR = bus.ADDR[7:0];
        if (bus.WR && !cpu_blocked) begin
          bus.OAM_WE    = 1'b1;
          bus.OAM_WDATA = bus.MMIO_DATA_out;
        end
      end
    end
  end

  always_comb begin
    bus.OAM_CPU_DATA = 8'h00;
    if (cpu_oam_sel) begin
      bus.OAM_CPU_DATA = cpu_blocked ? 8'hFF : bus.OAM_RDATA;
    end else if (cpu_unusable_sel) begin
      bus.OAM_CPU_DATA = 8'h00;
    end
  end

  assign bus.PPU_OAM_DATA = dma_active ? 8'hFF : bus.OAM_RDATA;
  assign bus.DMA_ACTIVE   = dma_active;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - directed self-checking bench for oam_dma_arbiter.
module tb_oam_dma_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_if bus();

  oam_dma_arbiter #(.STEP_CYCLES(4), .OAM_BYTES(160)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  oam [0:159];
  logic [7:0]  src_q = 8'h00;
  int          checks = 0;
  int          failures = 0;
  int          we_cnt = 0;
  logic [15:0] src_log [$];

  // Source memory pattern: base C1 gives i^5A, base D0 gives i^4B
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A ^ 8'hC1;
  endfunction

  always @(posedge clk) begin
    if (bus.SRC_RD) src_q <= src_byte(bus.SRC_ADDR);
    if (bus.OAM_WE && bus.OAM_ADDR < 8'd160) oam[bus.OAM_ADDR] <= bus.OAM_WDATA;
  end

  assign bus.SRC_DATA  = src_q;
  assign bus.OAM_RDATA = (bus.OAM_ADDR < 8'd160) ? oam[bus.OAM_ADDR] : 8'h00;

  always @(negedge clk) begin
    if (bus.OAM_WE) we_cnt <= we_cnt + 1;
    if (bus.SRC_RD) src_log.push_back(bus.SRC_ADDR);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic trig(input logic [7:0] val);
    bus.ADDR          = 16'hFF46;
    bus.WR            = 1'b1;
    bus.MMIO_DATA_out = val;
    @(negedge clk);
    bus.WR   = 1'b0;
    bus.ADDR = 16'h0000;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (!bus.DMA_ACTIVE) break;
      @(negedge clk);
    end
    check(tag, bus.DMA_ACTIVE, 0);
  endtask

  task automatic wait_src(input logic [15:0] a, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.SRC_RD && bus.SRC_ADDR == a) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, found, 1);
  endtask

  task automatic check_oam(input string tag, input int split, input logic [7:0] lo_x, input logic [7:0] hi_x);
    int errs = 0;
    logic [7:0] e;
    for (int i = 0; i < 160; i++) begin
      e = 8'(i) ^ ((i < split) ? lo_x : hi_x);
      if (oam[i] !== e) errs++;
    end
    check(tag, errs, 0);
  endtask

  initial begin
    int we0;
    int log0;
    int bad;
    int hi;
    rst = 1'b1;
    bus.ADDR = 16'h0000; bus.WR = 1'b0; bus.RD = 1'b0; bus.MMIO_DATA_out = 8'h00;
    bus.PPU_MODE = 2'd0; bus.PPU_RD = 1'b0; bus.PPU_ADDR = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_dma_active", bus.DMA_ACTIVE, 0);
    check("rst_src_rd", bus.SRC_RD, 0);
    check("rst_oam_we", bus.OAM_WE, 0);
    check("rst_src_addr", bus.SRC_ADDR, 16'h0000);
    check("rst_oam_addr", bus.OAM_ADDR, 8'h00);
    check("rst_oam_wdata", bus.OAM_WDATA, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // 1: full transfer from C100, 641-cycle timing, 160 writes
    we0 = we_cnt;
    trig(8'hC1);
    check("t1_setup_active", bus.DMA_ACTIVE, 1);
    check("t1_setup_no_rd", bus.SRC_RD, 0);
    @(negedge clk);
    check("t1_first_rd", bus.SRC_RD, 1);
    check("t1_first_addr", bus.SRC_ADDR, 16'hC100);
    repeat (639) @(negedge clk);
    check("t1_active_640", bus.DMA_ACTIVE, 1);
    @(negedge clk);
    check("t1_active_641", bus.DMA_ACTIVE, 0);
    check("t1_we_pulses", we_cnt - we0, 160);
    check_oam("t1_oam", 160, 8'h5A, 8'h5A);

    // 2: echo source E3 folds to C3
    log0 = src_log.size();
    trig(8'hE3);
    wait_idle("t2_done");
    check("t2_rd_count", src_log.size() - log0, 160);
    bad = 0; hi = 0;
    for (int i = 0; i < 160; i++) begin
      if (src_log[log0 + i] !== 16'hC300 + 16'(i)) bad++;
      if (src_log[log0 + i] >= 16'hE000) hi++;
    end
    check("t2_addr_seq", bad, 0);
    check("t2_no_echo", hi, 0);

    // 3: restart at idx 50
    trig(8'hC0);
    wait_src(16'hC032, "t3_reach_idx50");
    trig(8'hD0);
    check("t3_setup_no_rd", bus.SRC_RD, 0);
    check("t3_setup_active", bus.DMA_ACTIVE, 1);
    @(negedge clk);
    check("t3_restart_rd", bus.SRC_RD, 1);
    check("t3_restart_addr", bus.SRC_ADDR, 16'hD000);
    wait_idle("t3_done");
    check_oam("t3_oam", 160, 8'h4B, 8'h4B);

    // 4: CPU access under PPU modes
    @(negedge clk);
    bus.PPU_MODE = 2'd3; bus.ADDR = 16'hFE10; bus.RD = 1'b1;
    #1 check("t4_rd_draw", bus.OAM_CPU_DATA, 8'hFF);
    bus.PPU_MODE = 2'd2; bus.RD = 1'b0; bus.WR = 1'b1; bus.MMIO_DATA_out = 8'h77;
    @(negedge clk);
    bus.WR = 1'b0;
    check("t4_wr_scan_dropped", oam[16], 8'h5B);
    bus.PPU_MODE = 2'd0; bus.WR = 1'b1;
    @(negedge clk);
    bus.WR = 1'b0;
    check("t4_wr_hblank", oam[16], 8'h77);
    bus.RD = 1'b1;
    #1 check("t4_rd_hblank", bus.OAM_CPU_DATA, 8'h77);
    bus.ADDR = 16'hFEA0;
    #1 check("t4_rd_unusable", bus.OAM_CPU_DATA, 8'h00);
    bus.RD = 1'b0; bus.WR = 1'b1; bus.MMIO_DATA_out = 8'h33;
    #1 check("t4_wr_unusable", bus.OAM_WE, 0);
    bus.WR = 1'b0; bus.ADDR = 16'h0000;

    // 5: PPU read during and after DMA
    @(negedge clk);
    bus.PPU_MODE = 2'd2; bus.PPU_RD = 1'b1; bus.PPU_ADDR = 16'hFE04;
    trig(8'hC1);
    repeat (21) @(negedge clk);
    check("t5_dma_rd", bus.SRC_RD, 1);
    check("t5_oam_addr_dma", bus.OAM_ADDR, 8'h05);
    check("t5_ppu_data_dma", bus.PPU_OAM_DATA, 8'hFF);
    wait_idle("t5_done");
    #1;
    check("t5_oam_addr_ppu", bus.OAM_ADDR, 8'h04);
    check("t5_ppu_data", bus.PPU_OAM_DATA, 8'h5E);
    bus.PPU_RD = 1'b0; bus.PPU_MODE = 2'd0;

    // 6: async reset after byte 79 is written
    @(negedge clk);
    trig(8'hD0);
    wait_src(16'hD04F, "t6_reach_idx79");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_active", bus.DMA_ACTIVE, 0);
    check("t6_rst_we", bus.OAM_WE, 0);
    check("t6_rst_rd", bus.SRC_RD, 0);
    @(negedge clk);
    rst = 1'b0;
    check_oam("t6_oam_partial", 80, 8'h4B, 8'h5A);
    @(negedge clk);
    trig(8'hC1);
    @(negedge clk);
    check("t6_restart_addr", bus.SRC_ADDR, 16'hC100);
    wait_idle("t6_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
